// File: rtl/rob_retire.sv
// Reorder buffer with in-order retire.
// Rename allocates rows at the tail, functional units mark rows complete by
// index, and the head row retires once complete. Each retire returns the old
// physical destination register to the free list.
// Optional build macro: ROB_CMPL_BYPASS_EN lets a completion aimed at the head
// row raise retire_valid in the same cycle (zero-cycle completion-to-retire).
module rob_retire #(
    parameter int DEPTH  = 16,
    parameter int IDX_W  = 4,
    parameter int PREG_W = 7,
    parameter int NCMPL  = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   alloc_valid,
    output logic                   alloc_ready,
    input  logic [PREG_W-1:0]      alloc_preg_dst,
    input  logic [PREG_W-1:0]      alloc_old_preg_dst,
    input  logic                   alloc_reg_write,
    output logic [IDX_W-1:0]       alloc_rob_idx,
    input  logic [NCMPL-1:0]       cmpl_valid,
    input  logic [NCMPL*IDX_W-1:0] cmpl_rob_idx,
    output logic                   retire_valid,
    input  logic                   retire_ready,
    output logic [IDX_W-1:0]       retire_rob_idx,
    output logic [PREG_W-1:0]      retire_preg_dst,
    output logic                   free_valid,
    output logic [PREG_W-1:0]      free_preg,
    output logic [IDX_W:0]         count,
    output logic                   empty,
    output logic                   full
);

    localparam int PTR_W = IDX_W + 1;
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    logic [PTR_W-1:0]  head_reg;
    logic [PTR_W-1:0]  tail_reg;
    logic [PTR_W-1:0]  head_next;
    logic [PTR_W-1:0]  tail_next;
    logic [IDX_W-1:0]  head_idx;
    logic [IDX_W-1:0]  tail_idx;

    // Per-row status bits (reset) and payload storage (no reset needed).
    logic [DEPTH-1:0]  valid_reg;
    logic [DEPTH-1:0]  complete_reg;
    logic [DEPTH-1:0]  reg_write_mem;
    logic [PREG_W-1:0] preg_dst_mem [DEPTH];
    logic [PREG_W-1:0] old_preg_mem [DEPTH];

    logic [DEPTH-1:0]  cmpl_hit;
    logic              head_done;
    logic              full_int;
    logic              alloc_fire;
    logic              retire_fire;

    assign head_idx = head_reg[IDX_W-1:0];
    assign tail_idx = tail_reg[IDX_W-1:0];

    assign full_int = (head_reg[IDX_W-1:0] == tail_reg[IDX_W-1:0]) &&
                      (head_reg[IDX_W] != tail_reg[IDX_W]);
    assign full     = full_int;
    assign empty    = (head_reg == tail_reg);
    assign count    = tail_reg - head_reg;

    // Allocation only looks at registered fullness; retire cannot free a slot
    // for allocation in the same cycle, which keeps retire_ready off this path.
    assign alloc_ready   = !full_int;
    assign alloc_rob_idx = tail_idx;
    assign alloc_fire    = alloc_valid && !full_int && !flush;

    // Decode every completion port into a per-row hit vector; duplicates OR.
    always_comb begin
        cmpl_hit = '0;
        for (int k = 0; k < NCMPL; k++) begin
            if (cmpl_valid[k]) begin
                cmpl_hit[cmpl_rob_idx[k*IDX_W +: IDX_W]] = 1'b1;
            end
        end
    end

`ifdef ROB_CMPL_BYPASS_EN
    // A completion arriving for the head row counts as done immediately.
    assign head_done = complete_reg[head_idx] || cmpl_hit[head_idx];
`else
    // Completion becomes visible to retire one cycle after the strobe.
    assign head_done = complete_reg[head_idx];
`endif

    assign retire_valid    = valid_reg[head_idx] && head_done;
    assign retire_rob_idx  = head_idx;
    assign retire_preg_dst = preg_dst_mem[head_idx];
    assign retire_fire     = retire_valid && retire_ready && !flush;

    // The free list sees the old mapping only when the retiring op wrote a reg.
    assign free_valid = retire_fire && reg_write_mem[head_idx];
    assign free_preg  = old_preg_mem[head_idx];

    // Pointer advance on each handshake.
    always_comb begin
        head_next = head_reg;
        tail_next = tail_reg;
        if (retire_fire) begin
            head_next = head_reg + PTR_ONE;
        end
        if (alloc_fire) begin
            tail_next = tail_reg + PTR_ONE;
        end
    end

    // Pointer registers; flush rewinds both to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_reg <= '0;
            tail_reg <= '0;
        end else if (flush) begin
            head_reg <= '0;
            tail_reg <= '0;
        end else begin
            head_reg <= head_next;
            tail_reg <= tail_next;
        end
    end

    // Per-row valid/complete tracking. Allocation and retire never target the
    // same row in one cycle, and a completion only sticks to a live row.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_row
        logic row_alloc;
        logic row_retire;

        assign row_alloc  = alloc_fire && (tail_idx == IDX_W'(gi));
        assign row_retire = retire_fire && (head_idx == IDX_W'(gi));

        // Row status update.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                valid_reg[gi]    <= 1'b0;
                complete_reg[gi] <= 1'b0;
            end else if (flush) begin
                valid_reg[gi]    <= 1'b0;
                complete_reg[gi] <= 1'b0;
            end else if (row_alloc) begin
                valid_reg[gi]    <= 1'b1;
                complete_reg[gi] <= 1'b0;
            end else if (row_retire) begin
                valid_reg[gi]    <= 1'b0;
                complete_reg[gi] <= 1'b0;
            end else if (cmpl_hit[gi] && valid_reg[gi]) begin
                complete_reg[gi] <= 1'b1;
            end
        end

        // Payload capture at allocation; contents are don't-care until valid.
        always_ff @(posedge clk) begin
            if (row_alloc) begin
                reg_write_mem[gi] <= alloc_reg_write;
                preg_dst_mem[gi]  <= alloc_preg_dst;
                old_preg_mem[gi]  <= alloc_old_preg_dst;
            end
        end
    end

endmodule

// File: tb/tb_rob_retire.sv
// Directed bench for rob_retire: stimulus pushes expected retire transactions
// into a scoreboard queue; a monitor pops and compares on every retire fire.
module tb_rob_retire;

    localparam int IDX_W  = 4;
    localparam int PREG_W = 7;
    localparam int NCMPL  = 3;

`ifdef ROB_CMPL_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic                   clk;
    logic                   rst_n;
    logic                   flush;
    logic                   alloc_valid;
    logic                   alloc_ready;
    logic [PREG_W-1:0]      alloc_preg_dst;
    logic [PREG_W-1:0]      alloc_old_preg_dst;
    logic                   alloc_reg_write;
    logic [IDX_W-1:0]       alloc_rob_idx;
    logic [NCMPL-1:0]       cmpl_valid;
    logic [NCMPL*IDX_W-1:0] cmpl_rob_idx;
    logic                   retire_valid;
    logic                   retire_ready;
    logic [IDX_W-1:0]       retire_rob_idx;
    logic [PREG_W-1:0]      retire_preg_dst;
    logic                   free_valid;
    logic [PREG_W-1:0]      free_preg;
    logic [IDX_W:0]         count;
    logic                   empty;
    logic                   full;

    rob_retire #(.DEPTH(16), .IDX_W(IDX_W), .PREG_W(PREG_W), .NCMPL(NCMPL)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
        .alloc_preg_dst(alloc_preg_dst), .alloc_old_preg_dst(alloc_old_preg_dst),
        .alloc_reg_write(alloc_reg_write), .alloc_rob_idx(alloc_rob_idx),
        .cmpl_valid(cmpl_valid), .cmpl_rob_idx(cmpl_rob_idx),
        .retire_valid(retire_valid), .retire_ready(retire_ready),
        .retire_rob_idx(retire_rob_idx), .retire_preg_dst(retire_preg_dst),
        .free_valid(free_valid), .free_preg(free_preg),
        .count(count), .empty(empty), .full(full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [IDX_W-1:0]  idx;
        logic [PREG_W-1:0] preg;
        logic              fv;
        logic [PREG_W-1:0] fp;
    } exp_t;

    exp_t exp_q[$];
    int   total_cnt = 0;
    int   pass_cnt  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total_cnt++;
        if (act === req) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic push_exp(input logic [IDX_W-1:0] idx, input logic [PREG_W-1:0] preg,
                            input logic fv, input logic [PREG_W-1:0] fp);
        exp_t e;
        e.idx = idx; e.preg = preg; e.fv = fv; e.fp = fp;
        exp_q.push_back(e);
    endtask

    // Monitor: every retire fire is matched against the head of the queue.
    always @(negedge clk) begin
        if (rst_n && !flush && retire_valid && retire_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_retire", {28'd0, retire_rob_idx}, 32'hFFFF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                $display("retire idx=%0d preg=%0d free_valid=%0d free_preg=%0d",
                         retire_rob_idx, retire_preg_dst, free_valid, free_preg);
                check("retire_idx", {28'd0, retire_rob_idx}, {28'd0, e.idx});
                check("retire_preg", {25'd0, retire_preg_dst}, {25'd0, e.preg});
                check("free_valid", {31'd0, free_valid}, {31'd0, e.fv});
                check("free_preg", {25'd0, free_preg}, {25'd0, e.fp});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cmpl(input int port, input logic [IDX_W-1:0] idx);
        cmpl_valid[port] = 1'b1;
        cmpl_rob_idx[port*IDX_W +: IDX_W] = idx;
    endtask

    // One allocation handshake; checks the index offered in the fire cycle.
    task automatic do_alloc(input logic [PREG_W-1:0] p, input logic [PREG_W-1:0] o,
                            input logic rw, input logic [IDX_W-1:0] exp_idx);
        alloc_valid = 1'b1; alloc_preg_dst = p; alloc_old_preg_dst = o; alloc_reg_write = rw;
        @(negedge clk);
        $display("alloc idx=%0d preg=%0d old=%0d rw=%0d", alloc_rob_idx, p, o, rw);
        check("alloc_idx", {28'd0, alloc_rob_idx}, {28'd0, exp_idx});
        step();
        alloc_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; alloc_valid = 1'b0; alloc_preg_dst = '0;
        alloc_old_preg_dst = '0; alloc_reg_write = 1'b0; cmpl_valid = '0;
        cmpl_rob_idx = '0; retire_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_count", {27'd0, count}, 32'd0);
        check("rst_empty", {31'd0, empty}, 32'd1);
        check("rst_full", {31'd0, full}, 32'd0);
        check("rst_alloc_ready", {31'd0, alloc_ready}, 32'd1);
        check("rst_retire_valid", {31'd0, retire_valid}, 32'd0);
        check("rst_free_valid", {31'd0, free_valid}, 32'd0);
        rst_n = 1'b1;
        step();

        // Three allocations, out-of-order completion, in-order retire.
        for (int i = 0; i < 3; i++) begin
            do_alloc(PREG_W'(33 + i), PREG_W'(1 + i), 1'b1, IDX_W'(i));
        end
        @(negedge clk);
        check("alloc3_count", {27'd0, count}, 32'd3);
        check("alloc3_retire_valid", {31'd0, retire_valid}, 32'd0);
        step();
        retire_ready = 1'b1;
        push_exp(4'd0, 7'd33, 1'b1, 7'd1);
        set_cmpl(0, 4'd2);
        step();
        cmpl_valid = '0;
        set_cmpl(1, 4'd0);
        step();
        cmpl_valid = '0;
        step();
        step();
        @(negedge clk);
        check("idx1_blocks", {31'd0, retire_valid}, 32'd0);
        check("blocked_count", {27'd0, count}, 32'd2);
        push_exp(4'd1, 7'd34, 1'b1, 7'd2);
        push_exp(4'd2, 7'd35, 1'b1, 7'd3);
        step();
        set_cmpl(2, 4'd1);
        step();
        cmpl_valid = '0;
        repeat (3) step();
        @(negedge clk);
        check("drain_count", {27'd0, count}, 32'd0);
        check("drain_empty", {31'd0, empty}, 32'd1);
        step();

        // Flush with five entries plus concurrent alloc and completions.
        retire_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            do_alloc(PREG_W'(50 + i), PREG_W'(70 + i), 1'b1, IDX_W'(3 + i));
        end
        flush = 1'b1; alloc_valid = 1'b1; alloc_preg_dst = 7'd99;
        set_cmpl(0, 4'd3); set_cmpl(1, 4'd4); set_cmpl(2, 4'd5);
        @(negedge clk);
        check("flush_free_valid", {31'd0, free_valid}, 32'd0);
        step();
        flush = 1'b0; alloc_valid = 1'b0; cmpl_valid = '0;
        @(negedge clk);
        $display("flush count=%0d empty=%0d alloc_idx=%0d", count, empty, alloc_rob_idx);
        check("flush_count", {27'd0, count}, 32'd0);
        check("flush_empty", {31'd0, empty}, 32'd1);
        check("flush_alloc_idx", {28'd0, alloc_rob_idx}, 32'd0);
        check("flush_retire_valid", {31'd0, retire_valid}, 32'd0);
        step();
        retire_ready = 1'b1;
        repeat (2) step();
        retire_ready = 1'b0;

        // Fill to full from index 0; row 0 does not write a register.
        for (int i = 0; i < 16; i++) begin
            do_alloc(PREG_W'(40 + i), PREG_W'(60 + i), (i != 0), IDX_W'(i));
        end
        @(negedge clk);
        check("full_flag", {31'd0, full}, 32'd1);
        check("full_alloc_ready", {31'd0, alloc_ready}, 32'd0);
        check("full_count", {27'd0, count}, 32'd16);
        step();
        alloc_valid = 1'b1; alloc_preg_dst = 7'd120;
        @(negedge clk);
        check("rej_alloc_idx", {28'd0, alloc_rob_idx}, 32'd0);
        step();
        alloc_valid = 1'b0;
        @(negedge clk);
        check("rej_count", {27'd0, count}, 32'd16);
        step();
        push_exp(4'd0, 7'd40, 1'b0, 7'd60);
        retire_ready = 1'b1;
        set_cmpl(2, 4'd0);
        step();
        cmpl_valid = '0;
        step();
        retire_ready = 1'b0;
        @(negedge clk);
        check("after_ret_count", {27'd0, count}, 32'd15);
        check("after_ret_ready", {31'd0, alloc_ready}, 32'd1);
        step();
        do_alloc(7'd100, 7'd101, 1'b1, 4'd0);
        @(negedge clk);
        check("wrap_full", {31'd0, full}, 32'd1);
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;

        // Completion-to-retire latency on a single entry.
        do_alloc(7'd90, 7'd91, 1'b1, 4'd0);
        push_exp(4'd0, 7'd90, 1'b1, 7'd91);
        retire_ready = 1'b1;
        set_cmpl(1, 4'd0);
        @(negedge clk);
        check("lat_rv_same_cycle", {31'd0, retire_valid}, {31'd0, BYP});
        step();
        cmpl_valid = '0;
        @(negedge clk);
        check("lat_count_next", {27'd0, count}, BYP ? 32'd0 : 32'd1);
        step();
        @(negedge clk);
        check("lat_count_final", {27'd0, count}, 32'd0);
        retire_ready = 1'b0;
        repeat (3) step();
        check("scoreboard_drained", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    // Hard bound so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
